// File: rtl/hidden_neuron_mac.sv
// Single-neuron multiply-accumulate: streams numInputs samples against weights, adds bias, emits one result.
// Optional ReLU activation on the output is enabled by defining HIDDEN_NEURON_RELU_EN.
module hidden_neuron_mac #(
    parameter int numInputs    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [dataWidth-1:0] in_data,
    output logic                        in_ready,
    input  logic signed [dataWidth-1:0] bias,
    output logic                        ren,
    output logic [addressWidth:0]       raddr,
    input  logic signed [dataWidth-1:0] wout,
    output logic                        out_valid,
    output logic signed [dataWidth-1:0] out_data
);

    localparam int ACCW = 2 * dataWidth;
    localparam logic [addressWidth:0] LAST_IDX = (addressWidth + 1)'(numInputs - 1);
    localparam logic [addressWidth:0] IDX_ONE  = {{addressWidth{1'b0}}, 1'b1};
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic signed [dataWidth-1:0] OUT_MAX = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic signed [dataWidth-1:0] OUT_MIN = {1'b1, {(dataWidth-1){1'b0}}};

    typedef enum logic [1:0] {ACC, DRAIN, BIAS, OUT} state_t;

    state_t                        r_state;
    logic [addressWidth:0]         r_index;
    logic [1:0]                    r_drain_cnt;
    logic                          r_d1_valid;
    logic signed [dataWidth-1:0]   r_in_d1;
    logic                          r_p_valid;
    logic signed [ACCW-1:0]        r_prod;
    logic signed [ACCW-1:0]        r_acc;
    logic                          r_out_valid;
    logic signed [dataWidth-1:0]   r_out_data;

    logic                          w_accept;
    logic signed [ACCW-1:0]        w_in_ext;
    logic signed [ACCW-1:0]        w_w_ext;
    logic signed [ACCW-1:0]        w_bias_shift;
    logic signed [ACCW-1:0]        w_acc_bias;
    logic signed [ACCW-1:0]        w_shifted;
    logic                          w_in_range;
    logic signed [dataWidth-1:0]   w_sat;
    logic signed [dataWidth-1:0]   w_result;

    function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                       input logic signed [ACCW-1:0] b);
        logic signed [ACCW:0] s;
        s = {a[ACCW-1], a} + {b[ACCW-1], b};
        if (s[ACCW] != s[ACCW-1])
            sat_add = s[ACCW] ? ACC_MIN : ACC_MAX;
        else
            sat_add = s[ACCW-1:0];
    endfunction

    assign in_ready = (r_state == ACC) && !rst;
    assign w_accept = in_valid && in_ready;
    assign ren      = w_accept;
    assign raddr    = w_accept ? r_index : '0;

    // Operands widened first so the product is a full-width signed multiply.
    assign w_in_ext     = {{(ACCW-dataWidth){r_in_d1[dataWidth-1]}}, r_in_d1};
    assign w_w_ext      = {{(ACCW-dataWidth){wout[dataWidth-1]}}, wout};
    assign w_bias_shift = {{(ACCW-dataWidth){bias[dataWidth-1]}}, bias} <<< fracBits;
    assign w_acc_bias   = sat_add(r_acc, w_bias_shift);
    assign w_shifted    = w_acc_bias >>> fracBits;

    assign w_in_range = (&w_shifted[ACCW-1:dataWidth-1]) || !(|w_shifted[ACCW-1:dataWidth-1]);
    assign w_sat      = w_in_range ? w_shifted[dataWidth-1:0]
                                   : (w_shifted[ACCW-1] ? OUT_MIN : OUT_MAX);

`ifdef HIDDEN_NEURON_RELU_EN
    assign w_result = w_sat[dataWidth-1] ? '0 : w_sat;
`else
    assign w_result = w_sat;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACC;
            r_index     <= '0;
            r_drain_cnt <= '0;
            r_d1_valid  <= 1'b0;
            r_in_d1     <= '0;
            r_p_valid   <= 1'b0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_d1_valid  <= w_accept;
            r_in_d1     <= in_data;
            r_p_valid   <= r_d1_valid;
            r_prod      <= w_in_ext * w_w_ext;
            r_out_valid <= 1'b0;

            if (r_p_valid)
                r_acc <= sat_add(r_acc, r_prod);

            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        if (r_index == LAST_IDX) begin
                            r_index     <= '0;
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_index <= r_index + IDX_ONE;
                        end
                    end
                end
                DRAIN: begin
                    // Three cycles cover the in_data delay, product and accumulate stages.
                    if (r_drain_cnt == 2'd2)
                        r_state <= BIAS;
                    else
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                end
                BIAS: begin
                    r_acc       <= w_acc_bias;
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    r_acc   <= '0;
                    r_state <= ACC;
                end
                default: r_state <= ACC;
            endcase
        end
    end

endmodule

// File: doc/hidden_neuron_mac.md
HIDDEN_NEURON_MAC -- requirements
Module: hidden_neuron_mac

Interface
REQ-001 Parameter numInputs, default 784: weights and inputs accumulated per output.
REQ-002 Parameter addressWidth, default 10: weight address width; raddr is addressWidth+1 bits.
REQ-003 Parameter dataWidth, default 16: signed two's-complement width of inputs, weights, bias and output.
REQ-004 Parameter fracBits, default 12: fractional bits of the shared fixed-point format.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  in_data holds a valid input sample this cycle.
REQ-008 in_data  in  dataWidth  signed input sample.
REQ-009 in_ready  out  1  block accepts a sample this cycle.
REQ-010 bias  in  dataWidth  signed bias, sampled in BIAS state; must be static while busy.
REQ-011 ren  out  1  weight-memory read enable.
REQ-012 raddr  out  addressWidth+1  weight-memory read address.
REQ-013 wout  in  dataWidth  weight from memory, valid one cycle after ren.
REQ-014 out_valid  out  1  single-cycle pulse; out_data valid.
REQ-015 out_data  out  dataWidth  signed neuron result.

Function
REQ-016 States: ACC, DRAIN, BIAS, OUT; reset enters ACC.
REQ-017 in_ready=1 only in ACC; a sample is accepted when in_valid&&in_ready.
REQ-018 On accept: ren=1 and raddr=index of the sample (0..numInputs-1) in the same cycle; index counter then increments; ren=0 otherwise.
REQ-019 Accepted in_data delayed one cycle to align with wout; product (2*dataWidth signed) registered the following cycle; accumulated the cycle after (accept at t -> accumulator updated at t+3).
REQ-020 Accumulator is 2*dataWidth signed, saturating at max/min on overflow, never wraps.
REQ-021 Accepting sample numInputs-1: index resets to 0, state -> DRAIN; in_ready=0 from the next cycle.
REQ-022 DRAIN lasts until the last product is accumulated (3 cycles), then -> BIAS.
REQ-023 BIAS: accumulator += bias sign-extended and shifted left fracBits, saturating; -> OUT next cycle.
REQ-024 OUT: out_data = accumulator arithmetic-shifted right fracBits, saturated to dataWidth; out_valid=1 for exactly that cycle; accumulator cleared; -> ACC.
REQ-025 Idle cycles (in_valid=0) in ACC are permitted anywhere in the stream; they hold the index and do not add to the accumulator.
REQ-026 Gap from last accept to out_valid is exactly 5 cycles; next sample accepted at earliest the cycle after out_valid.

Reset
REQ-027 rst asserted at any cycle, including mid-stream or DRAIN: next cycle state=ACC, index=0, accumulator=0, pipeline valid flags=0.
REQ-028 Reset values: in_ready=0 during rst then 1, ren=0, raddr=0, out_valid=0, out_data=0.
REQ-029 No partial result from an aborted stream ever reaches out_valid.

Configuration
REQ-030 Macro HIDDEN_NEURON_RELU_EN defined: out_data = 0 when saturated result is negative, else result.
REQ-031 Macro undefined: out_data is the signed saturated result with no activation; timing identical either way.

Verification
REQ-032 numInputs=4, fracBits=12, weights 1.0 (4096), inputs 0.5 (2048) x4, bias 0 -> out_data=8192, out_valid 5 cycles after last accept.
REQ-033 Same, bias=-4096, RELU_EN undefined -> out_data=4096; inputs -0.5 with RELU_EN defined -> out_data=0.
REQ-034 Weights and inputs 32767 x784, bias 32767 -> accumulator saturates, out_data=32767; negated inputs -> -32768 (no RELU).
REQ-035 Random in_valid gaps over 4-sample stream -> raddr sequence 0,1,2,3 on ren cycles only; result equals gap-free run.
REQ-036 rst after 2 of 4 samples -> no out_valid; fresh 4-sample stream gives the clean expected value and raddr restarts at 0.
REQ-037 Back-to-back streams -> in_ready=0 during DRAIN/BIAS/OUT; second result independent of first (accumulator cleared).
